// File: rtl/info_frame_pkg.sv
// Shared InfoFrame types, limits, FSM state encoding and header packing.
// Imported by the builder and by any fixed-content InfoFrame generator.
package info_frame_pkg;

   localparam logic [6:0] VENDOR = 7'h01;
   localparam logic [6:0] AVI    = 7'h02;
   localparam logic [6:0] SPD    = 7'h03;
   localparam logic [6:0] AUDIO  = 7'h04;

   localparam int MAX_PB = 27;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FINAL = 2'd2,
      PEND  = 2'd3
   } state_t;

   // {HB2, HB1, HB0} with the InfoFrame marker bit set in HB0
   function automatic logic [23:0] pack_header(input logic [6:0] frame_type,
                                               input logic [7:0] version,
                                               input logic [4:0] length);
      return {3'b000, length, version, 1'b1, frame_type};
   endfunction

endpackage

// File: rtl/info_frame_pack.sv
// Combinational PB0..PB27 to four 7-byte subpackets; sub[i] holds PB(7i) in its low byte.
// Zero latency, no flow control.
module info_frame_pack
   import info_frame_pkg::*;
(
   input  logic [MAX_PB:0][7:0] pb,
   output logic [3:0][55:0]     sub
);

   for (genvar i = 0; i < 4; i++) begin : g_sub
      assign sub[i] = pb[7*i +: 7];
   end

endmodule

// File: rtl/info_frame_builder.sv
// Serially loaded InfoFrame builder with checksum and double-buffered output; new frame visible n+3 cycles after start.
// Byte input stalls on byte_valid gaps; a finished frame waits in PEND until the scheduler consumes the active one.
module info_frame_builder
   import info_frame_pkg::*;
#(
   parameter int MAX_LENGTH = 27
) (
   input  logic             clk_pixel,
   input  logic             reset,
   input  logic             start,
   input  logic [6:0]       frame_type,
   input  logic [7:0]       version,
   input  logic [4:0]       length,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             busy,
   output logic             error,
   input  logic             frame_consumed,
   output logic [23:0]      header,
   output logic [3:0][55:0] sub,
   output logic             frame_valid
);

   localparam logic [4:0] MAX_LEN = 5'(MAX_LENGTH);

   state_t                state;
   logic [MAX_PB:0][7:0]  shadow;
   logic [3:0][55:0]      shadow_sub;
   logic [23:0]           cfg_header;
   logic [4:0]            cfg_length;
   logic [4:0]            idx;
   logic [7:0]            sum;
   logic [23:0]           start_header;
   logic [7:0]            start_sum;

   assign start_header = pack_header(frame_type, version, length);
   assign start_sum    = start_header[7:0] + start_header[15:8] + start_header[23:16];

   info_frame_pack u_pack (
      .pb  (shadow),
      .sub (shadow_sub)
   );

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state       <= IDLE;
         shadow      <= '0;
         cfg_header  <= '0;
         cfg_length  <= '0;
         idx         <= '0;
         sum         <= '0;
         header      <= '0;
         sub         <= '0;
         frame_valid <= 1'b0;
         byte_ready  <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
      end else begin
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (length == 5'd0 || length > MAX_LEN) begin
                     error <= 1'b1;
                  end else begin
                     cfg_header <= start_header;
                     cfg_length <= length;
                     // Clearing here keeps bytes of a longer previous frame out of this one
                     shadow     <= '0;
                     sum        <= start_sum;
                     idx        <= 5'd1;
                     byte_ready <= 1'b1;
                     busy       <= 1'b1;
                     state      <= LOAD;
                  end
               end
            end
            LOAD: begin
               // byte_ready is held high for the whole of LOAD, so byte_valid alone is the handshake
               if (byte_valid) begin
                  shadow[idx] <= byte_data;
                  sum         <= sum + byte_data;
                  if (idx == cfg_length) begin
                     byte_ready <= 1'b0;
                     state      <= FINAL;
                  end else begin
                     idx <= idx + 5'd1;
                  end
               end
            end
            FINAL: begin
               shadow[0] <= ~sum + 8'd1;
               state     <= PEND;
            end
            PEND: begin
               if (!frame_valid || frame_consumed) begin
                  header      <= cfg_header;
                  sub         <= shadow_sub;
                  frame_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_info_frame_builder.sv
// Bench for info_frame_builder: vector table, hand-built corner sequences and random frames vs a byte-level model.
module tb_info_frame_builder;
   import info_frame_pkg::*;

   logic             clk_pixel = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [6:0]       frame_type = '0;
   logic [7:0]       version = '0;
   logic [4:0]       length = '0;
   logic [7:0]       byte_data = '0;
   logic             byte_valid = 1'b0;
   logic             byte_ready;
   logic             busy;
   logic             error;
   logic             frame_consumed = 1'b0;
   logic [23:0]      header;
   logic [3:0][55:0] sub;
   logic             frame_valid;
   logic [223:0]     sub_flat;

   assign sub_flat = sub;

   always #5 clk_pixel = ~clk_pixel;

   info_frame_builder #(.MAX_LENGTH(27)) dut (
      .clk_pixel      (clk_pixel),
      .reset          (reset),
      .start          (start),
      .frame_type     (frame_type),
      .version        (version),
      .length         (length),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .busy           (busy),
      .error          (error),
      .frame_consumed (frame_consumed),
      .header         (header),
      .sub            (sub),
      .frame_valid    (frame_valid)
   );

   int           errors = 0;
   int           checks = 0;
   logic [7:0]   pl [1:27];
   logic [23:0]  exp_header = '0;
   logic [223:0] exp_sub = '0;
   logic         exp_valid = 1'b0;

   typedef struct {
      logic [6:0]  t;
      logic [7:0]  v;
      logic [4:0]  l;
      logic [7:0]  b1;
      logic [23:0] exp_h;
      logic [7:0]  exp_pb0;
   } vec_t;

   vec_t tbl [4];

   task automatic step();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic chk_w(input string name, input logic [223:0] act, input logic [223:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, req);
      end
   endtask

   // Whole frame from the rules: zeroed PB array, payload, PB0 = negated byte sum
   task automatic model(input logic [6:0] t, input logic [7:0] v, input logic [4:0] l,
                        output logic [23:0] h, output logic [223:0] s);
      logic [7:0] pb [0:27];
      int         total;
      h     = {3'b000, l, v, 1'b1, t};
      total = int'(h[7:0]) + int'(h[15:8]) + int'(h[23:16]);
      for (int b = 0; b < 28; b++) pb[b] = 8'h00;
      for (int b = 1; b <= int'(l); b++) begin
         pb[b] = pl[b];
         total += int'(pl[b]);
      end
      pb[0] = 8'((256 - (total % 256)) % 256);
      s = '0;
      for (int b = 0; b < 28; b++) s[8*b +: 8] = pb[b];
   endtask

   task automatic chk_sum(input string name);
      int s;
      s = 0;
      for (int b = 0; b < 3; b++) s += int'(header[8*b +: 8]);
      for (int b = 0; b < 28; b++) s += int'(sub_flat[8*b +: 8]);
      chk_w(name, 224'(s % 256), 224'(0));
   endtask

   // Called in an IDLE cycle; returns in the first cycle showing the new frame
   task automatic run_frame(input logic [6:0] t, input logic [7:0] v, input logic [4:0] l,
                            input bit gaps, input int hold);
      logic [23:0]  nh;
      logic [223:0] ns;
      int           i;
      int           guard;
      model(t, v, l, nh, ns);
      chk_b("idle_busy", busy, 1'b0);
      chk_b("idle_ready", byte_ready, 1'b0);
      start = 1'b1; frame_type = t; version = v; length = l;
      step();
      start = 1'b0;
      i = 1;
      guard = 0;
      while (i <= int'(l) && guard < 500) begin
         chk_b("load_ready", byte_ready, 1'b1);
         chk_b("load_no_error", error, 1'b0);
         byte_valid     = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         byte_data      = byte_valid ? pl[i] : 8'($urandom);
         frame_consumed = gaps ? 1'($urandom) : 1'b0;
         if (gaps && guard == 0) begin
            start  = 1'b1;
            length = 5'd0;
         end
         step();
         start = 1'b0;
         if (byte_valid) i++;
         guard++;
      end
      byte_valid     = 1'b0;
      frame_consumed = 1'b0;
      if (guard >= 500) begin
         errors++;
         checks++;
         $display("FAIL load_timeout: accepted %0d of %0d bytes", i - 1, l);
      end
      chk_b("final_ready", byte_ready, 1'b0);
      chk_b("final_busy", busy, 1'b1);
      chk_b("final_error", error, 1'b0);
      if (!exp_valid) chk_b("final_fv", frame_valid, 1'b0);
      step();
      chk_b("pend_busy", busy, 1'b1);
      chk_b("pend_ready", byte_ready, 1'b0);
      if (!exp_valid) begin
         chk_b("pend_fv", frame_valid, 1'b0);
         step();
      end else begin
         for (int k = 0; k < hold; k++) begin
            chk_w("hold_header", 224'(header), 224'(exp_header));
            chk_w("hold_sub", sub_flat, exp_sub);
            step();
            chk_b("hold_busy", busy, 1'b1);
         end
         frame_consumed = 1'b1;
         chk_w("consume_header", 224'(header), 224'(exp_header));
         step();
         frame_consumed = 1'b0;
      end
      chk_w("new_header", 224'(header), 224'(nh));
      chk_w("new_sub", sub_flat, ns);
      chk_b("new_fv", frame_valid, 1'b1);
      chk_b("new_busy", busy, 1'b0);
      chk_sum("new_checksum");
      exp_header = nh;
      exp_sub    = ns;
      exp_valid  = 1'b1;
   endtask

   task automatic reject(input logic [4:0] l);
      start = 1'b1; length = l;
      step();
      start = 1'b0;
      chk_b("reject_error", error, 1'b1);
      chk_b("reject_busy", busy, 1'b0);
      chk_b("reject_ready", byte_ready, 1'b0);
      chk_w("reject_header", 224'(header), 224'(exp_header));
      chk_b("reject_fv", frame_valid, exp_valid);
      step();
      chk_b("reject_pulse_end", error, 1'b0);
      chk_b("reject_still_idle", busy, 1'b0);
   endtask

   initial begin
      tbl[0] = '{t: AUDIO,  v: 8'h01, l: 5'd10, b1: 8'h01, exp_h: 24'h0A0184, exp_pb0: 8'h70};
      tbl[1] = '{t: AVI,    v: 8'h02, l: 5'd13, b1: 8'h00, exp_h: 24'h0D0282, exp_pb0: 8'h6F};
      tbl[2] = '{t: SPD,    v: 8'h01, l: 5'd25, b1: 8'h10, exp_h: 24'h190183, exp_pb0: 8'h53};
      tbl[3] = '{t: VENDOR, v: 8'h01, l: 5'd27, b1: 8'hFF, exp_h: 24'h1B0181, exp_pb0: 8'h64};

      step(); step();
      reset = 1'b0;
      step();
      chk_w("rst_header", 224'(header), 224'(0));
      chk_w("rst_sub", sub_flat, 224'(0));
      chk_b("rst_fv", frame_valid, 1'b0);
      chk_b("rst_ready", byte_ready, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_error", error, 1'b0);

      foreach (tbl[r]) begin
         for (int b = 1; b <= 27; b++) pl[b] = 8'h00;
         pl[1] = tbl[r].b1;
         run_frame(tbl[r].t, tbl[r].v, tbl[r].l, 1'b0, 0);
         chk_w("tbl_header", 224'(header), 224'(tbl[r].exp_h));
         chk_w("tbl_sub0", 224'(sub[0]), 224'({tbl[r].b1, tbl[r].exp_pb0}));
         chk_w("tbl_sub_hi", 224'(sub_flat[223:56]), 224'(0));
      end

      // AVI with handshake gaps, then held in PEND for several cycles
      for (int b = 1; b <= 27; b++) pl[b] = 8'($urandom);
      run_frame(AVI, 8'h02, 5'd13, 1'b1, 3);

      reject(5'd0);
      reject(5'd28);

      for (int b = 1; b <= 27; b++) pl[b] = 8'hFF;
      run_frame(SPD, 8'h01, 5'd27, 1'b0, 0);
      pl[1] = 8'h11;
      pl[2] = 8'h22;
      run_frame(SPD, 8'h01, 5'd2, 1'b0, 1);
      chk_w("stale_cleared", 224'(sub_flat[223:24]), 224'(0));

      for (int b = 1; b <= 27; b++) pl[b] = 8'($urandom);
      start = 1'b1; frame_type = SPD; version = 8'h01; length = 5'd20;
      step();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         byte_valid = 1'b1;
         byte_data  = pl[k];
         step();
      end
      byte_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_w("midrst_header", 224'(header), 224'(0));
      chk_w("midrst_sub", sub_flat, 224'(0));
      chk_b("midrst_fv", frame_valid, 1'b0);
      chk_b("midrst_busy", busy, 1'b0);
      chk_b("midrst_ready", byte_ready, 1'b0);
      exp_header = '0;
      exp_sub    = '0;
      exp_valid  = 1'b0;
      run_frame(SPD, 8'h01, 5'd20, 1'b0, 0);

      for (int n = 0; n < 15; n++) begin
         for (int b = 1; b <= 27; b++) pl[b] = 8'($urandom);
         run_frame(7'($urandom), 8'($urandom), 5'($urandom_range(1, 27)),
                   1'($urandom), $urandom_range(0, 3));
         for (int k = 0; k < 2; k++) begin
            frame_consumed = 1'($urandom);
            step();
            chk_w("idle_header", 224'(header), 224'(exp_header));
            chk_w("idle_sub", sub_flat, exp_sub);
            chk_b("idle_not_busy", busy, 1'b0);
         end
         frame_consumed = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
